// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, data width, receiver states and
// a 2-of-3 majority helper.
package uart_pkg;

    localparam int unsigned UART_CYCLES_PER_BIT = 104;
    localparam int unsigned UART_DATA_BITS      = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous inputs; resets to 1 so an idle
// high line does not look like an edge when reset releases.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronization into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Recovers bytes from the asynchronous rx line, pulses
// valid with each good byte and frame_err on a low stop bit.
// Build option: define UART_RX_MAJORITY_EN to decide each sample point by a
// 2-of-3 vote over the last three synchronized samples.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = UART_CYCLES_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CYCLES_PER_BIT + 1);
    localparam int unsigned HALF  = CYCLES_PER_BIT / 2;
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] START_TGT = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_TGT   = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    logic                      w_sample;

    uart_rx_state_t            r_state;
    uart_rx_state_t            w_state_next;
    logic [CNT_W-1:0]          r_cycles;
    logic [CNT_W-1:0]          w_cycles_next;
    logic [IDX_W-1:0]          r_index;
    logic [IDX_W-1:0]          w_index_next;
    logic [UART_DATA_BITS-1:0] r_data;
    logic [UART_DATA_BITS-1:0] w_data_next;
    logic [UART_DATA_BITS-1:0] r_out;
    logic [UART_DATA_BITS-1:0] w_out_next;
    logic                      r_valid;
    logic                      w_valid_next;
    logic                      r_frame_err;
    logic                      w_frame_err_next;
    logic                      r_busy;

    sync_2ff u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two previous synchronized samples for the vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_sample = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cycles    <= '0;
            r_index     <= '0;
            r_data      <= '0;
            r_out       <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cycles    <= w_cycles_next;
            r_index     <= w_index_next;
            r_data      <= w_data_next;
            r_out       <= w_out_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_busy      <= (w_state_next != IDLE);
        end
    end

    // Next-state, bit timing and sampling decisions
    always_comb begin
        w_state_next     = r_state;
        w_cycles_next    = r_cycles;
        w_index_next     = r_index;
        w_data_next      = r_data;
        w_out_next       = r_out;
        w_valid_next     = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            IDLE: begin
                w_cycles_next = '0;
                w_index_next  = '0;
                if (!w_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_cycles_next = r_cycles + CNT_W'(1);
                if (r_cycles == START_TGT) begin
                    if (w_sample) begin
                        // Low pulse too short to be a start bit
                        w_state_next = IDLE;
                    end else begin
                        w_cycles_next = '0;
                        w_state_next  = DATA;
                    end
                end
            end
            DATA: begin
                w_cycles_next = r_cycles + CNT_W'(1);
                if (r_cycles == BIT_TGT) begin
                    w_data_next[r_index] = w_sample;
                    w_cycles_next        = '0;
                    if (r_index == LAST_IDX) begin
                        w_state_next = STOP;
                    end else begin
                        w_index_next = r_index + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                w_cycles_next = r_cycles + CNT_W'(1);
                if (r_cycles == BIT_TGT) begin
                    if (w_sample) begin
                        w_out_next   = r_data;
                        w_valid_next = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not
                // decoded as a stream of zero bytes
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign out       = r_out;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit. A negedge monitor logs
// every valid/frame_err pulse; each test task compares that log and the
// outputs against bytes and timings computed from the frame format.
module tb_uart_rx;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] dut_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_out = 8'h00;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         busy_seen = 0;

    uart_rx #(.CYCLES_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .out       (dut_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log output pulses away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                got_q.push_back(dut_out);
                got_cyc.push_back(cyc);
            end
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (valid && frame_err) both_cnt <= both_cnt + 1;
            if (busy) busy_seen <= busy_seen + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // Drive one frame; p returns the posedge number that first sees the start bit.
    // glitch inverts the line for one cycle in the middle of each data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit glitch, output int p);
        logic v;
        p = 0;
        for (int bi = 0; bi < 10; bi++) begin
            if (bi == 0)      v = 1'b0;
            else if (bi == 9) v = stop_bit;
            else              v = b[bi-1];
            for (int k = 0; k < int'(CPB); k++) begin
                @(negedge clk);
                if (bi == 0 && k == 0) p = cyc + 1;
                rx = v ^ (glitch && bi >= 1 && bi <= 8 && k == 4);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_out !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_outputs: got out=%h v=%b fe=%b busy=%b want 00 0 0 0",
                     dut_out, valid, frame_err, busy);
        else n_pass++;
        rst_n = 1'b1;
        idle(6);
        n_checks++;
        if (busy !== 1'b0 || got_q.size() != 0 || ferr_cnt != 0)
            $display("FAIL reset_release_idle: busy=%b valids=%0d ferrs=%0d want 0 0 0",
                     busy, got_q.size(), ferr_cnt);
        else n_pass++;
    endtask

    task automatic test_basic;
        int s, f, p;
        s = got_q.size();
        f = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, p);
        idle(4);
        exp_out = 8'hA5;
        n_checks++;
        if (got_q.size() != s + 1)
            $display("FAIL basic_count: got %0d pulses want 1", got_q.size() - s);
        else n_pass++;
        n_checks++;
        if (got_q.size() <= s || got_q[s] !== 8'hA5)
            $display("FAIL basic_byte: got %h want a5", (got_q.size() > s) ? got_q[s] : 8'hxx);
        else n_pass++;
        n_checks++;
        if (got_cyc.size() <= s || got_cyc[s] != p + 4 + 9 * int'(CPB) + 2)
            $display("FAIL basic_timing: valid at cycle %0d want %0d",
                     (got_cyc.size() > s) ? got_cyc[s] : -1, p + 4 + 9 * int'(CPB) + 2);
        else n_pass++;
        n_checks++;
        if (ferr_cnt != f || dut_out !== 8'hA5 || busy !== 1'b0)
            $display("FAIL basic_after: ferrs=%0d out=%h busy=%b want 0 a5 0",
                     ferr_cnt - f, dut_out, busy);
        else n_pass++;
    endtask

    task automatic test_start_glitch;
        int s, f, b;
        s = got_q.size();
        f = ferr_cnt;
        b = busy_seen;
        repeat (2) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(12);
        n_checks++;
        if (busy_seen <= b)
            $display("FAIL glitch_busy_pulse: busy cycles %0d want >0", busy_seen - b);
        else n_pass++;
        n_checks++;
        if (got_q.size() != s || ferr_cnt != f || busy !== 1'b0)
            $display("FAIL glitch_no_pulse: valids=%0d ferrs=%0d busy=%b want 0 0 0",
                     got_q.size() - s, ferr_cnt - f, busy);
        else n_pass++;
    endtask

    task automatic test_frame_err;
        int s, f, p;
        s = got_q.size();
        f = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, p);
        repeat (40) begin
            @(negedge clk);
            rx = 1'b0;
        end
        n_checks++;
        if (ferr_cnt != f + 1)
            $display("FAIL ferr_count: got %0d pulses want 1", ferr_cnt - f);
        else n_pass++;
        n_checks++;
        if (dut_out !== exp_out || got_q.size() != s)
            $display("FAIL ferr_out_kept: out=%h valids=%0d want %h 0",
                     dut_out, got_q.size() - s, exp_out);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1)
            $display("FAIL ferr_wait_high: busy=%b want 1 while line low", busy);
        else n_pass++;
        idle(8);
        n_checks++;
        if (busy !== 1'b0 || got_q.size() != s || ferr_cnt != f + 1 || both_cnt != 0)
            $display("FAIL ferr_release: busy=%b valids=%0d ferrs=%0d both=%0d want 0 0 1 0",
                     busy, got_q.size() - s, ferr_cnt - f, both_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int s, p1, p2;
        s = got_q.size();
        send_frame(8'h00, 1'b1, 1'b0, p1);
        send_frame(8'hFF, 1'b1, 1'b0, p2);
        idle(4);
        exp_out = 8'hFF;
        n_checks++;
        if (got_q.size() != s + 2)
            $display("FAIL b2b_count: got %0d pulses want 2", got_q.size() - s);
        else n_pass++;
        n_checks++;
        if (got_q.size() < s + 2 || got_q[s] !== 8'h00 || got_q[s+1] !== 8'hFF)
            $display("FAIL b2b_bytes: got %h %h want 00 ff",
                     (got_q.size() > s) ? got_q[s] : 8'hxx,
                     (got_q.size() > s + 1) ? got_q[s+1] : 8'hxx);
        else n_pass++;
        n_checks++;
        if (got_cyc.size() < s + 2 || got_cyc[s+1] != p2 + 4 + 9 * int'(CPB) + 2)
            $display("FAIL b2b_timing: second valid at %0d want %0d",
                     (got_cyc.size() > s + 1) ? got_cyc[s+1] : -1, p2 + 4 + 9 * int'(CPB) + 2);
        else n_pass++;
    endtask

    task automatic test_random;
        int s, p;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        s = got_q.size();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0, p);
            idle(int'($urandom_range(0, 3)));
        end
        idle(4);
        exp_out = exp_q[exp_q.size()-1];
        n_checks++;
        if (got_q.size() != s + exp_q.size())
            $display("FAIL rand_count: got %0d pulses want %0d", got_q.size() - s, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q.size() <= s + i || got_q[s+i] !== exp_q[i])
                $display("FAIL rand_byte%0d: got %h want %h", i,
                         (got_q.size() > s + i) ? got_q[s+i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int s, f, p;
        logic [7:0] b;
        b = 8'h5A;
        s = got_q.size();
        f = ferr_cnt;
        // start bit plus data bits 0..3, then half of bit 4
        for (int bi = 0; bi < 6; bi++) begin
            for (int k = 0; k < int'(CPB); k++) begin
                if (bi == 5 && k == 4) break;
                @(negedge clk);
                rx = (bi == 0) ? 1'b0 : b[bi-1];
            end
        end
        rst_n = 1'b0;
        exp_out = 8'h00;
        @(negedge clk);
        rx = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || dut_out !== 8'h00)
            $display("FAIL rstmid_during: busy=%b valid=%b out=%h want 0 0 00",
                     busy, valid, dut_out);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        n_checks++;
        if (got_q.size() != s || ferr_cnt != f || busy !== 1'b0)
            $display("FAIL rstmid_aborted: valids=%0d ferrs=%0d busy=%b want 0 0 0",
                     got_q.size() - s, ferr_cnt - f, busy);
        else n_pass++;
        send_frame(8'h81, 1'b1, 1'b0, p);
        idle(4);
        exp_out = 8'h81;
        n_checks++;
        if (got_q.size() != s + 1 || got_q[s] !== 8'h81 || dut_out !== 8'h81)
            $display("FAIL rstmid_next_frame: pulses=%0d out=%h want 1 81",
                     got_q.size() - s, dut_out);
        else n_pass++;
    endtask

    task automatic test_glitch_data;
        int s, f, p;
        logic [7:0] b;
        logic [7:0] want;
        b = 8'($urandom);
        s = got_q.size();
        f = ferr_cnt;
`ifdef UART_RX_MAJORITY_EN
        want = b;
`else
        want = ~b;
`endif
        send_frame(b, 1'b1, 1'b1, p);
        idle(4);
        exp_out = want;
        n_checks++;
        if (got_q.size() != s + 1 || ferr_cnt != f)
            $display("FAIL gdata_count: valids=%0d ferrs=%0d want 1 0",
                     got_q.size() - s, ferr_cnt - f);
        else n_pass++;
        n_checks++;
        if (got_q.size() <= s || got_q[s] !== want)
            $display("FAIL gdata_byte: got %h want %h (sent %h)",
                     (got_q.size() > s) ? got_q[s] : 8'hxx, want, b);
        else n_pass++;
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_start_glitch();
        test_frame_err();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_glitch_data();
        n_checks++;
        if (both_cnt != 0)
            $display("FAIL valid_ferr_overlap: %0d cycles with both high want 0", both_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: it recovers 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) from an asynchronous `rx` line. Each good byte is presented on a parallel output with a one-cycle `valid` pulse. It is the receive-side counterpart of `uart_tx`, uses the same `CYCLES_PER_BIT` bit timing, and sits between the board RX pin and the byte consumer.

## Interface
- `CYCLES_PER_BIT`, default 104: clock cycles per serial bit. Must be ≥ 4.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `rx` input, 1 bit: serial line. Idle high. Asynchronous to `clk`.
- `out` output, 8 bits: last correctly received byte. Holds its value until the next good frame.
- `valid` output, 1 bit: high for exactly one cycle when `out` is updated.
- `frame_err` output, 1 bit: high for exactly one cycle when a stop bit samples low.
- `busy` output, 1 bit: high whenever state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. All logic below uses the synchronized signal `rx_s`.
- Constants:
  - `HALF = CYCLES_PER_BIT/2`, using integer division.
  - Counter `cycles` is `$clog2(CYCLES_PER_BIT+1)` bits wide.
  - Bit index `index` is 3 bits.
  - Shift register `data` is 8 bits.
- State machine states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: `cycles`←0, `index`←0. When `rx_s`=0, go to START.
- START: increment `cycles`. At `cycles`==HALF-1, sample `rx_s`:
  - Sample 1 (glitch): return to IDLE. No error is flagged.
  - Sample 0: `cycles`←0, go to DATA.
- DATA: increment `cycles`. At `cycles`==CYCLES_PER_BIT-1:
  - Sample `rx_s` into `data[index]` and set `cycles`←0.
  - If `index`==7, go to STOP. Otherwise `index`←`index`+1.
- STOP: increment `cycles`. At `cycles`==CYCLES_PER_BIT-1, sample `rx_s`:
  - Sample 1: `out`←`data`, pulse `valid`, go to IDLE.
  - Sample 0: pulse `frame_err`, leave `out` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition (line held low) from being decoded as repeated 0x00 frames.
- Illegal state encoding: go to IDLE on the next edge.

## Timing
- Reset values: `out`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state=IDLE, and both synchronizer flops = 1.
- Reset asserted mid-frame: the in-progress frame is discarded immediately and no pulse is issued. After release, the block waits in IDLE for the next falling edge.
- Define t0 as the edge at which IDLE sees `rx_s`=0. Synchronizer delay is 2 cycles after the pin falls.
- Sample edges relative to t0:
  - Start-bit check: t0+HALF.
  - Data bit i (i = 0..7): t0+HALF+(i+1)·CYCLES_PER_BIT.
  - Stop bit: t0+HALF+9·CYCLES_PER_BIT.
- `valid` / `frame_err` are registered. They are high during the cycle that follows the stop-sample edge.
- Back-to-back frames: IDLE is re-entered on the stop-sample edge, so a start edge arriving on the very next cycle is accepted. No extra idle bit is required.
- `valid` and `frame_err` are never high in the same cycle.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined: every sample point (start, data, stop) uses a 2-of-3 majority vote.
  - The three samples are `rx_s` at counts target-2, target-1 and target, where target is the sample count defined above.
  - The decision is made at target, so the state-transition timing is unchanged.
- Undefined: a single sample of `rx_s` at the target count, as described above.
- The port list is identical in both builds.

## Structure
- Package `uart_pkg`:
  - State enum `uart_rx_state_t`.
  - Default `CYCLES_PER_BIT` constant, shared with `uart_tx`.
  - `UART_DATA_BITS`=8.
- Sub-module `sync_2ff`: 1-bit, 2-flop synchronizer with async active-low reset and reset value 1. The codebase reuses it for other asynchronous inputs.

## Test plan
All scenarios use `CYCLES_PER_BIT`=8 and drive `rx` at 8 clocks per bit.
- Frame for 0xA5 with stop bit 1 → `out`=8'hA5, `valid` high for one cycle at t0+4+72 (+1 registered), `frame_err` stays 0.
- `rx` pulled low for 2 cycles, then high → `busy` pulses, block returns to IDLE at the start check, no `valid`, no `frame_err`.
- Frame for 0x3C with stop bit 0, then `rx` held low for 40 cycles → one `frame_err` pulse, `out` keeps its previous value, state stays WAIT_HIGH until `rx` rises, and no 0x00 byte is produced.
- Back-to-back frames 0x00 then 0xFF, with the second start bit immediately after the first stop bit → two `valid` pulses, `out`=0x00 then 0xFF.
- `rst_n` asserted at data bit 4 of 0x5A, released, then a full 0x81 frame sent → no pulse for the aborted frame, then `out`=0x81 with `valid`.
- With `UART_RX_MAJORITY_EN` defined: 0xA5 with a 1-cycle inverted glitch exactly on each bit's target count → `out`=0xA5. Without the macro, the same stimulus produces a corrupted byte.
